lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store unit sitting directly upstream of the word-addressed data memory (dmem), between the MIPS execute/memory stage and the RAM.
- Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Sub-word loads: lane extraction with sign/zero extension.
- Sub-word stores: read-modify-write, because dmem only writes full words.
- Stalls the pipeline via req_ready while a multi-cycle access is in flight.

Parameters:
DMEM_WORDS, 256, number of 32-bit words in dmem; valid word index range 0..DMEM_WORDS-1
ADDR_W, 32, width of byte address and of the dmem address bus

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-low reset
req_valid  input  1  pipeline presents a memory request
req_ready  output  1  unit accepts request this cycle; 1 only in IDLE with reset high
mem_op  input  4  = MIPS opcode[3:0]: 0000 LB, 0001 LH, 0011 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1011 SW
byte_addr  input  ADDR_W  byte address of access
store_data  input  32  store operand; sub-word stores use low bits
load_data  output  32  extended load result, registered
load_valid  output  1  one-cycle pulse, load_data valid
store_done  output  1  one-cycle pulse in the cycle the dmem write is issued
misalign_err  output  1  one-cycle pulse: misaligned or illegal request, dropped
mem_write  output  1  to dmem MemWrite
mem_addr  output  ADDR_W  to dmem addr: word index = byte_addr[ADDR_W-1:2], zero-extended
mem_wd  output  32  to dmem WD
mem_rd  input  32  from dmem RD (combinational read)

Behaviour:
- Reset (reset==0 at posedge):
  - state -> IDLE.
  - load_data=0, load_valid=0, store_done=0, misalign_err=0, mem_write=0, mem_addr=0, mem_wd=0.
  - req_ready=0 while reset low.
- Mid-operation reset: pending request discarded; no mem_write ever issued for it.
- Byte lanes are little-endian: offset 0 = bits[7:0], offset 3 = bits[31:24]. Halfword offset 0 = [15:0], offset 2 = [31:16].
- Misaligned or illegal request:
  - Misaligned: halfword with byte_addr[0]=1; word with byte_addr[1:0]!=0.
  - Illegal: any unlisted mem_op.
  - Handling: no dmem access and no load_valid; misalign_err pulses.
- Request latching: op/address/data captured only at acceptance (req_valid & req_ready). Requests while req_ready=0 are ignored; the requester holds them.
- FSM:
  - IDLE: req_ready=1.
    - On acceptance: error -> ERR; load -> LOAD; SW -> WRITE (mem_wd_reg = store_data); SB/SH -> MERGE.
  - ERR: misalign_err=1 for this cycle; -> IDLE.
  - LOAD: mem_addr = word index, mem_write=0. Extract the lane from mem_rd, then sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes the word through. Result registered into load_data; load_valid=1 next cycle; -> IDLE.
  - MERGE: mem_addr driven, mem_write=0. Replace the addressed byte/halfword of mem_rd with store_data[7:0]/[15:0], keeping the other lanes; register the merged word; -> WRITE.
  - WRITE: mem_write=1, mem_addr = word index, mem_wd = registered word, store_done=1; -> IDLE.
- mem_write is 0 in every state except WRITE.
- Latency (acceptance at edge T):
  - Load: LOAD during cycle T+1; load_valid at T+2.
  - SW: write at T+1.
  - SB/SH: merge at T+1, write at T+2.
  - Error: misalign_err at T+1.
- req_ready returns high the cycle after the last access state, so back-to-back requests are accepted every 2 (load/SW/error) or 3 (SB/SH) cycles.
- Read-after-write: a load accepted after a store completes reads the updated word, since the write commits at the WRITE edge.

Optional Feature:
LSU_RANGE_CHECK_EN
- Defined: word index >= DMEM_WORDS is treated as an error (ERR path, misalign_err pulse, no dmem access).
- Undefined: out-of-range addresses pass to dmem unchanged. Loads return whatever dmem drives (0); stores are dropped by dmem.

Test Plan:
- dmem word 4 = 0x8899AABB. LB byte_addr 0x11 -> load_data 0xFFFFFFAA, load_valid two cycles after acceptance. LBU 0x11 -> 0x000000AA.
- LH 0x12 -> 0xFFFF8899. LHU 0x12 -> 0x00008899. LW 0x10 -> 0x8899AABB. mem_write stays 0 throughout.
- SB 0x13 store_data 0x12345677 -> mem_write=1 at acceptance+2, mem_addr=4, mem_wd=0x7799AABB, store_done pulse. Then SH 0x10 store_data 0x0000CAFE -> mem_wd=0x7799CAFE.
- LW 0x12 and SH 0x11 -> misalign_err pulse at acceptance+1, no mem_write, no load_valid. mem_op 0111 -> same response.
- SH 0x10 accepted, reset low during MERGE -> no mem_write ever, word 4 unchanged, all outputs 0. After release, req_ready=1.
- SW 0x14 store_data 0xDEADBEEF, then LW 0x14 back-to-back -> load_data 0xDEADBEEF. With LSU_RANGE_CHECK_EN and DMEM_WORDS=256: LW 0x400 -> misalign_err.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store unit in front of a word-addressed data memory.
//
// Converts byte-addressed MIPS loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW)
// into whole-word dmem accesses:
//   - loads read the word, then extract the lane and sign/zero extend it;
//   - SB/SH read the word, merge the new lane in, then write the full word;
//   - SW writes the word directly.
// Misaligned halfword/word accesses and unknown opcodes are dropped and
// reported with a one-cycle misalign_err pulse.
//
// Optional build macro: LSU_RANGE_CHECK_EN
//   defined   -> a word index >= DMEM_WORDS is handled like a misaligned request
//   undefined -> out-of-range addresses are passed to dmem unchanged
//
// Ports:
//   clk, reset     rising-edge clock; synchronous active-low reset
//   req_valid      pipeline presents a request
//   req_ready      unit accepts a request this cycle (IDLE and out of reset)
//   mem_op         MIPS opcode[3:0] selecting the access type
//   byte_addr      byte address of the access
//   store_data     store operand (low byte/halfword for SB/SH)
//   load_data      registered, extended load result
//   load_valid     one-cycle pulse, load_data valid
//   store_done     one-cycle pulse in the cycle the dmem write is issued
//   misalign_err   one-cycle pulse, request was misaligned or illegal
//   mem_write      dmem write enable
//   mem_addr       dmem word index (byte_addr >> 2, zero-extended)
//   mem_wd         dmem write data
//   mem_rd         dmem combinational read data
//   dbg_state      current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. Op, address and data are captured only then; while
// req_ready is 0 the requester must hold its request and the unit ignores it.

module lsu_ctrl #(
  parameter int DMEM_WORDS = 256,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        mem_op,
  input  logic [ADDR_W-1:0] byte_addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              store_done,
  output logic              misalign_err,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd,
  output logic [2:0]        dbg_state
);

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1011;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_sdata;
  logic [31:0]       r_mem_wd;
  logic [31:0]       r_load_data;
  logic              r_load_valid;

  logic              w_accept;
  logic              w_req_err;
  logic [ADDR_W-1:0] w_word_idx;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_ext;
  logic [31:0]       w_merged;

  assign w_accept   = req_valid & req_ready;
  assign w_word_idx = {2'b00, r_addr[ADDR_W-1:2]};

  // Request legality: unknown opcodes and misaligned halfword/word accesses.
  always_comb begin
    w_req_err = 1'b0;
    case (mem_op)
      OP_LB, OP_LBU, OP_SB: w_req_err = 1'b0;
      OP_LH, OP_LHU, OP_SH: w_req_err = byte_addr[0];
      OP_LW, OP_SW:         w_req_err = (byte_addr[1:0] != 2'b00);
      default:              w_req_err = 1'b1;
    endcase
`ifdef LSU_RANGE_CHECK_EN
    if ({2'b00, byte_addr[ADDR_W-1:2]} >= ADDR_W'(DMEM_WORDS)) begin
      w_req_err = 1'b1;
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and dmem/handshake outputs. Write-side strobes are gated by
  // reset so a reset asserted during WRITE never commits the pending store.
  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    mem_write    = 1'b0;
    store_done   = 1'b0;
    misalign_err = 1'b0;
    mem_addr     = '0;
    mem_wd       = 32'h0;
    case (r_state)
      S_IDLE: begin
        req_ready = reset;
        if (w_accept) begin
          if (w_req_err)          w_next = S_ERR;
          else if (!mem_op[3])    w_next = S_LOAD;
          else if (mem_op == OP_SW) w_next = S_WRITE;
          else                    w_next = S_MERGE;
        end
      end
      S_LOAD: begin
        mem_addr = w_word_idx;
        w_next   = S_IDLE;
      end
      S_MERGE: begin
        mem_addr = w_word_idx;
        w_next   = S_WRITE;
      end
      S_WRITE: begin
        mem_write  = reset;
        store_done = reset;
        mem_addr   = w_word_idx;
        mem_wd     = r_mem_wd;
        w_next     = S_IDLE;
      end
      S_ERR: begin
        misalign_err = reset;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Little-endian lane selection from the word being read.
  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'd0: w_byte = mem_rd[7:0];
      2'd1: w_byte = mem_rd[15:8];
      2'd2: w_byte = mem_rd[23:16];
      2'd3: w_byte = mem_rd[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = r_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
  end

  always_comb begin
    w_load_ext = mem_rd;
    case (r_op)
      OP_LB:   w_load_ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_ext = {24'h0, w_byte};
      OP_LH:   w_load_ext = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_ext = {16'h0, w_half};
      default: w_load_ext = mem_rd;
    endcase
  end

  // Read-modify-write: replace only the addressed lane of the current word.
  always_comb begin
    w_merged = mem_rd;
    if (r_op == OP_SB) begin
      case (r_addr[1:0])
        2'd0: w_merged[7:0]   = r_sdata[7:0];
        2'd1: w_merged[15:8]  = r_sdata[7:0];
        2'd2: w_merged[23:16] = r_sdata[7:0];
        2'd3: w_merged[31:24] = r_sdata[7:0];
        default: w_merged = mem_rd;
      endcase
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_sdata;
    end else begin
      w_merged[15:0] = r_sdata;
    end
  end

  // Request capture and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op         <= 4'h0;
      r_addr       <= '0;
      r_sdata      <= 16'h0;
      r_mem_wd     <= 32'h0;
      r_load_data  <= 32'h0;
      r_load_valid <= 1'b0;
    end else begin
      r_load_valid <= 1'b0;
      if (w_accept) begin
        r_op    <= mem_op;
        r_addr  <= byte_addr;
        r_sdata <= store_data[15:0];
        if (mem_op == OP_SW) begin
          r_mem_wd <= store_data;
        end
      end
      if (r_state == S_LOAD) begin
        r_load_data  <= w_load_ext;
        r_load_valid <= 1'b1;
      end
      if (r_state == S_MERGE) begin
        r_mem_wd <= w_merged;
      end
    end
  end

  assign load_data  = r_load_data;
  assign load_valid = r_load_valid;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl.
// A small word-addressed dmem lives in the bench; expected results come from
// a byte-array reference memory and per-request rules (alignment, lane
// position, extension), independent of the unit's internal structure.

module tb_lsu_ctrl;

  localparam int ADDR_W     = 32;
  localparam int DMEM_WORDS = 256;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  mem_op = 4'h0;
  logic [31:0] byte_addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [31:0] load_data;
  logic        load_valid;
  logic        store_done;
  logic        misalign_err;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic [2:0]  dbg_state;

  lsu_ctrl #(.DMEM_WORDS(DMEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_op(mem_op), .byte_addr(byte_addr), .store_data(store_data),
    .load_data(load_data), .load_valid(load_valid),
    .store_done(store_done), .misalign_err(misalign_err),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .dbg_state(dbg_state)
  );

  // ---------------- bench dmem ----------------
  logic [31:0] dmem [0:DMEM_WORDS-1];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = 8'h0;
  logic [31:0] pre_val = 32'h0;

  always @(posedge clk) begin
    if (pre_en) dmem[pre_idx] <= pre_val;
    else if (mem_write && mem_addr < 32'(DMEM_WORDS)) dmem[mem_addr[7:0]] <= mem_wd;
  end
  assign mem_rd = (mem_addr < 32'(DMEM_WORDS)) ? dmem[mem_addr[7:0]] : 32'h0;

  // ---------------- scoreboard / reference model ----------------
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  ref_b [0:4*DMEM_WORDS-1];
  logic [31:0] last_load = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int op_size(input logic [3:0] op);
    case (op[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_err(input logic [3:0] op, input logic [31:0] addr);
    case (op)
      4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1011: ;
      default: return 1'b1;
    endcase
    if ((addr & 32'(op_size(op) - 1)) != 32'h0) return 1'b1;
`ifdef LSU_RANGE_CHECK_EN
    if ((addr >> 2) >= 32'(DMEM_WORDS)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    logic [31:0] base;
    base = addr & 32'hFFFF_FFFC;
    if (base >= 32'(4 * DMEM_WORDS)) return 32'h0;
    return {ref_b[base + 3], ref_b[base + 2], ref_b[base + 1], ref_b[base]};
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr);
    logic [31:0] v;
    v = ref_word(addr) >> (8 * addr[1:0]);
    case (op_size(op))
      1:       return op[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2:       return op[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] data);
    logic [31:0] w;
    int p;
    w = ref_word(addr);
    for (int k = 0; k < op_size(op); k++) begin
      p = int'(addr[1:0]) + k;
      w[p*8 +: 8] = data[k*8 +: 8];
    end
    return w;
  endfunction

  task automatic model_commit(input logic [31:0] addr, input logic [31:0] w);
    logic [31:0] base;
    base = addr & 32'hFFFF_FFFC;
    if (base < 32'(4 * DMEM_WORDS)) begin
      for (int k = 0; k < 4; k++) ref_b[base + 32'(k)] = w[k*8 +: 8];
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge where req_ready is back high.
  task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
    int          guard;
    bit          err;
    logic [31:0] idx;
    logic [31:0] wexp;
    logic [31:0] lexp;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    mem_op     = op;
    byte_addr  = addr;
    store_data = data;
    err  = model_err(op, addr);
    idx  = addr >> 2;
    wexp = 32'h0;
    if (!err && !op[3]) exp_q.push_back(model_load(op, addr));
    if (!err && op[3]) wexp = model_store(op, addr, data);
    @(posedge clk);
    @(negedge clk);
    // Busy cycles: present junk that must be ignored.
    req_valid  = 1'($urandom_range(0, 1));
    mem_op     = 4'($urandom_range(0, 15));
    byte_addr  = $urandom;
    store_data = $urandom;
    chk("busy_ready", 32'(req_ready), 32'd0);
    chk("lv_early", 32'(load_valid), 32'd0);
    if (err) begin
      chk("err_pulse", 32'(misalign_err), 32'd1);
      chk("err_nowrite", 32'(mem_write), 32'd0);
      chk("err_nodone", 32'(store_done), 32'd0);
      @(negedge clk);
      chk("err_end", 32'(misalign_err), 32'd0);
      chk("err_nolv", 32'(load_valid), 32'd0);
      chk("err_nowrite2", 32'(mem_write), 32'd0);
    end else if (!op[3]) begin
      chk("ld_noerr", 32'(misalign_err), 32'd0);
      chk("ld_nowrite", 32'(mem_write), 32'd0);
      chk("ld_addr", mem_addr, idx);
      @(negedge clk);
      chk("ld_valid", 32'(load_valid), 32'd1);
      chk("ld_nowrite2", 32'(mem_write), 32'd0);
      lexp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
      chk("ld_data", load_data, lexp);
      last_load = load_data;
    end else if (op == 4'b1011) begin
      chk("sw_write", 32'(mem_write), 32'd1);
      chk("sw_done", 32'(store_done), 32'd1);
      chk("sw_addr", mem_addr, idx);
      chk("sw_wd", mem_wd, wexp);
      chk("sw_noerr", 32'(misalign_err), 32'd0);
      model_commit(addr, wexp);
      @(negedge clk);
      chk("sw_end", 32'(mem_write), 32'd0);
      chk("sw_done_end", 32'(store_done), 32'd0);
    end else begin
      chk("rmw_nowrite", 32'(mem_write), 32'd0);
      chk("rmw_addr", mem_addr, idx);
      chk("rmw_nodone", 32'(store_done), 32'd0);
      @(negedge clk);
      chk("rmw_write", 32'(mem_write), 32'd1);
      chk("rmw_done", 32'(store_done), 32'd1);
      chk("rmw_addr2", mem_addr, idx);
      chk("rmw_wd", mem_wd, wexp);
      chk("rmw_busy", 32'(req_ready), 32'd0);
      model_commit(addr, wexp);
      @(negedge clk);
      chk("rmw_end", 32'(mem_write), 32'd0);
    end
    chk("ready_after", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  logic [3:0] legal_ops [0:7];
  logic [31:0] w;

  initial begin
    legal_ops = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1011};

    // Reset held while dmem and reference memory are preloaded.
    reset = 1'b0;
    for (int i = 0; i < DMEM_WORDS; i++) begin
      @(negedge clk);
      w = (i == 4) ? 32'h8899_AABB : $urandom;
      pre_en  = 1'b1;
      pre_idx = 8'(i);
      pre_val = w;
      for (int k = 0; k < 4; k++) ref_b[4*i + k] = w[k*8 +: 8];
    end
    @(negedge clk);
    pre_en = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_load_valid", 32'(load_valid), 32'd0);
    chk("rst_store_done", 32'(store_done), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Lane extraction on word 4 = 0x8899AABB.
    do_req(4'b0000, 32'h11, 32'h0); chk("tp_lb",  last_load, 32'hFFFF_FFAA);
    do_req(4'b0100, 32'h11, 32'h0); chk("tp_lbu", last_load, 32'h0000_00AA);
    do_req(4'b0001, 32'h12, 32'h0); chk("tp_lh",  last_load, 32'hFFFF_8899);
    do_req(4'b0101, 32'h12, 32'h0); chk("tp_lhu", last_load, 32'h0000_8899);
    do_req(4'b0011, 32'h10, 32'h0); chk("tp_lw",  last_load, 32'h8899_AABB);

    // Sub-word stores.
    do_req(4'b1000, 32'h13, 32'h1234_5677);
    @(negedge clk); chk("tp_sb_mem", dmem[4], 32'h7799_AABB);
    do_req(4'b1001, 32'h10, 32'h0000_CAFE);
    @(negedge clk); chk("tp_sh_mem", dmem[4], 32'h7799_CAFE);

    // Misaligned and illegal.
    do_req(4'b0011, 32'h12, 32'h0);
    do_req(4'b1001, 32'h11, 32'h5555);
    do_req(4'b0111, 32'h10, 32'h0);

    // Reset during MERGE of an accepted SH.
    req_valid = 1'b1; mem_op = 4'b1001; byte_addr = 32'h10; store_data = 32'h0000_1234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    chk("mid_rst_nowrite", 32'(mem_write), 32'd0);
    @(negedge clk);
    chk("mid_rst_write", 32'(mem_write), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_lv", 32'(load_valid), 32'd0);
    chk("mid_rst_done", 32'(store_done), 32'd0);
    chk("mid_rst_err", 32'(misalign_err), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_wd", mem_wd, 32'h0);
    @(negedge clk);
    chk("mid_rst_write2", 32'(mem_write), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_release", 32'(req_ready), 32'd1);
    chk("mid_rst_word4", dmem[4], ref_word(32'h10));

    // Read-after-write, back to back.
    do_req(4'b1011, 32'h14, 32'hDEAD_BEEF);
    do_req(4'b0011, 32'h14, 32'h0); chk("tp_raw", last_load, 32'hDEAD_BEEF);

    // Out-of-range word index (error only with the range check built in).
    do_req(4'b0011, 32'h400, 32'h0);
    do_req(4'b1011, 32'h404, 32'h0BAD_0BAD);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [3:0]  op;
      logic [31:0] addr;
      int          r;
      r = $urandom_range(0, 99);
      if (r < 70)      addr = $urandom_range(0, 63);
      else if (r < 90) addr = $urandom_range(0, 4 * DMEM_WORDS - 1);
      else             addr = $urandom_range(4 * DMEM_WORDS, 16 * DMEM_WORDS - 1);
      r = $urandom_range(0, 99);
      op = (r < 90) ? legal_ops[$urandom_range(0, 7)] : 4'($urandom_range(0, 15));
      do_req(op, addr, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Final memory image against the reference.
    @(negedge clk);
    for (int i = 0; i < DMEM_WORDS; i++) begin
      chk("final_mem", dmem[i], ref_word(32'(4 * i)));
    end
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
